// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder_if                                               |
// | Brief    : Load/store request and response bundle between MEM and dmem.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [ADDR_WIDTH-1:0]     req_addr;
  logic [DATA_WIDTH-1:0]     req_wdata;
  logic [DATA_WIDTH/8-1:0]   req_be;
  logic                      resp_valid;
  logic [DATA_WIDTH-1:0]     resp_rdata;
  logic                      mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, mem_stall
  );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                  |
// | Brief    : Fixed-latency word-addressed data memory with byte enables.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module dmem_responder #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int         c_depth  = 2 ** ADDR_WIDTH;
  localparam int         c_nbytes = DATA_WIDTH / 8;
  localparam bit         c_single = (LATENCY == 1);
  localparam logic [3:0] c_cnt_init = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]              r_state;
  logic [3:0]              r_cnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [c_nbytes-1:0]     r_be;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic [DATA_WIDTH-1:0]   r_mem [0:c_depth-1];

  logic                    w_ready;
  logic                    w_accept;
  logic                    w_enter_resp;
  logic                    w_commit;
  logic                    w_use_capture;
  logic                    w_we;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [c_nbytes-1:0]     w_be;
  logic [DATA_WIDTH-1:0]   w_old;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_ready  = (r_state != c_busy);
  assign w_accept = bus.req_valid & w_ready;

  // With single-cycle latency the access uses the live request; otherwise
  // it uses the copy captured at acceptance.
  assign w_enter_resp  = ((r_state == c_busy) && (r_cnt == 4'd0)) || (w_accept && c_single);
  assign w_commit      = w_enter_resp & ~rst;
  assign w_use_capture = (r_state == c_busy);
  assign w_we          = w_use_capture ? r_we    : bus.req_we;
  assign w_addr        = w_use_capture ? r_addr  : bus.req_addr;
  assign w_wdata       = w_use_capture ? r_wdata : bus.req_wdata;
  assign w_be          = w_use_capture ? r_be    : bus.req_be;
  assign w_old         = r_mem[w_addr];

  for (genvar gi = 0; gi < c_nbytes; gi++) begin : g_byte
    assign w_merged[8*gi +: 8] = w_be[gi] ? w_wdata[8*gi +: 8] : w_old[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        c_idle, c_resp: begin
          if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
            if (c_single) begin
              r_state <= c_resp;
            end else begin
              r_state <= c_busy;
              r_cnt   <= c_cnt_init;
            end
          end else begin
            r_state <= c_idle;
          end
        end
        c_busy: begin
          if (r_cnt == 4'd0) begin
            r_state <= c_resp;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= c_idle;
      endcase

      if (w_enter_resp) begin
        r_rdata <= w_we ? '0 : w_old;
      end
    end
  end

  // Storage has no reset; an in-flight store is dropped by gating with rst.
  always_ff @(posedge clk) begin
    if (w_commit && w_we) begin
      r_mem[w_addr] <= w_merged;
    end
  end

  assign bus.req_ready  = w_ready;
  assign bus.resp_valid = (r_state == c_resp);
  assign bus.resp_rdata = r_rdata;
  assign bus.mem_stall  = (r_state == c_busy) | (bus.req_valid & ~w_ready);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                               |
// | Brief    : Scoreboard bench over three responders (LATENCY 2, 1 and 4).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t sbq [$];

  logic        rv   [3];
  logic        rwe  [3];
  logic [5:0]  ra   [3];
  logic [31:0] rwd  [3];
  logic [3:0]  rbe  [3];
  logic        rdy  [3];
  logic        rspv [3];
  logic        stall[3];
  logic [31:0] rd   [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    dmem_responder_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();
    assign bus.req_valid = rv[gi];
    assign bus.req_we    = rwe[gi];
    assign bus.req_addr  = ra[gi];
    assign bus.req_wdata = rwd[gi];
    assign bus.req_be    = rbe[gi];
    assign rdy[gi]       = bus.req_ready;
    assign rspv[gi]      = bus.resp_valid;
    assign rd[gi]        = bus.resp_rdata;
    assign stall[gi]     = bus.mem_stall;
    dmem_responder #(
      .ADDR_WIDTH(6),
      .DATA_WIDTH(32),
      .LATENCY   ((gi == 0) ? 2 : ((gi == 1) ? 1 : 4))
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rspv[d] === 1'b1) begin
        if (sbq.size() == 0 || sbq[0].dut != d) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0 (cycle %0d)", d, cyc);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check($sformatf("rdata_dut%0d", d), rd[d], e.data);
          check($sformatf("resp_cycle_dut%0d", d), cyc, e.due);
        end
      end
    end
  end

  // Entered and left at a negedge; rv stays high on return unless last is set.
  task automatic issue(input int d, input bit we, input logic [5:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp, input int exp_wait,
                       input bit want, input bit last);
    int   n;
    exp_t e;
    n      = 0;
    rwe[d] = we;
    ra[d]  = a;
    rwd[d] = wd;
    rbe[d] = be;
    rv[d]  = 1'b1;
    while (rdy[d] !== 1'b1 && n < 40) begin
      check($sformatf("stall_busy_dut%0d", d), {31'd0, stall[d]}, 32'd1);
      @(negedge clk);
      n++;
    end
    if (n >= 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got no req_ready expected accept", d);
      rv[d] = 1'b0;
      return;
    end
    check($sformatf("stall_accept_dut%0d", d), {31'd0, stall[d]}, 32'd0);
    if (exp_wait >= 0) check($sformatf("wait_cycles_dut%0d", d), n, exp_wait);
    if (want) begin
      e.dut  = d;
      e.due  = cyc + lat_of(d);
      e.data = we ? 32'd0 : exp;
      sbq.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (last) rv[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; rwe[d] = 1'b0; ra[d] = '0; rwd[d] = '0; rbe[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("reset_ready", {31'd0, rdy[d]}, 32'd1);
      check("reset_resp_valid", {31'd0, rspv[d]}, 32'd0);
      check("reset_rdata", rd[d], 32'd0);
      check("reset_stall", {31'd0, stall[d]}, 32'd0);
    end
    rst = 1'b0;

    // LATENCY=2: accept right after reset, then load back the prior contents.
    issue(0, 1'b1, 6'd5, 32'h0BADF00D, 4'hF, 32'd0, 0, 1'b1, 1'b0);
    issue(0, 1'b0, 6'd5, 32'd0, 4'h0, 32'h0BADF00D, 1, 1'b1, 1'b1);
    drain();

    // Reset while BUSY drops the store of 0xDEADBEEF.
    issue(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 32'd0, 0, 1'b0, 1'b1);
    check("busy_before_reset", {31'd0, stall[0]}, 32'd1);
    rst = 1'b1;
    #1;
    check("midreset_resp_valid", {31'd0, rspv[0]}, 32'd0);
    check("midreset_rdata", rd[0], 32'd0);
    check("midreset_ready", {31'd0, rdy[0]}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    issue(0, 1'b0, 6'd5, 32'd0, 4'h0, 32'h0BADF00D, 0, 1'b1, 1'b1);
    drain();

    // Store then load, read-after-write.
    issue(0, 1'b1, 6'd3, 32'h12345678, 4'hF, 32'd0, 0, 1'b1, 1'b0);
    issue(0, 1'b0, 6'd3, 32'd0, 4'h0, 32'h12345678, 1, 1'b1, 1'b1);
    drain();

    // Byte enables, including an all-zero enable store.
    issue(0, 1'b1, 6'd7, 32'hAABBCCDD, 4'hF, 32'd0, 0, 1'b1, 1'b0);
    issue(0, 1'b1, 6'd7, 32'h11223344, 4'b0101, 32'd0, 1, 1'b1, 1'b0);
    issue(0, 1'b0, 6'd7, 32'd0, 4'h0, 32'hAA22CC44, 1, 1'b1, 1'b0);
    issue(0, 1'b1, 6'd7, 32'hFFFFFFFF, 4'h0, 32'd0, 1, 1'b1, 1'b0);
    issue(0, 1'b0, 6'd7, 32'd0, 4'h0, 32'hAA22CC44, 1, 1'b1, 1'b1);
    drain();

    // LATENCY=1 back-to-back stores then loads with req_valid held high.
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, 6'(i), 32'hC0DE0000 | 32'(i), 4'hF, 32'd0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      issue(1, 1'b0, 6'(i), 32'd0, 4'h0, 32'hC0DE0000 | 32'(i), 0, 1'b1, (i == 3));
    drain();

    // LATENCY=4: held request stalls 3 cycles and is accepted in the RESP cycle.
    issue(2, 1'b1, 6'd9, 32'hCAFE0001, 4'hF, 32'd0, 0, 1'b1, 1'b0);
    issue(2, 1'b0, 6'd9, 32'd0, 4'h0, 32'hCAFE0001, 3, 1'b1, 1'b0);
    issue(2, 1'b1, 6'd10, 32'h00000055, 4'hF, 32'd0, 3, 1'b1, 1'b1);
    drain();

    // Idle.
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check("idle_resp_valid", {31'd0, rspv[d]}, 32'd0);
        check("idle_stall", {31'd0, stall[d]}, 32'd0);
        check("idle_ready", {31'd0, rdy[d]}, 32'd1);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the pipelined RISC-V core.
- Sits on the MEM-stage side of the load/store interface. It accepts one request per handshake, waits a fixed latency, then returns a single-cycle response.
- Drives a stall indication back to the pipeline so hazard/stall logic can freeze earlier stages.
- Word-addressed storage with per-byte write enables.

Parameters:
ADDR_WIDTH, 6, word-address width; storage depth = 2**ADDR_WIDTH words
DATA_WIDTH, 32, data word width; must be a multiple of 8
LATENCY, 2, cycles from acceptance to response; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  pipeline presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_WIDTH  word address
req_wdata  input  DATA_WIDTH  store data
req_be  input  DATA_WIDTH/8  byte enables for stores; ignored for loads
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  DATA_WIDTH  load data; zero for store responses
mem_stall  output  1  pipeline must hold MEM and earlier stages

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, latency counter=0, captured request cleared.
  - resp_valid=0, resp_rdata=0.
  - Storage array is NOT reset.
  - A request in flight is dropped; its store is not committed.
  - The first accept is possible in the first cycle after rst deasserts.
- Handshake:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - On acceptance, req_we/addr/wdata/be are captured. Request inputs are don't-care afterwards.
  - The requester holds a request stable while req_valid=1 and req_ready=0.
- States:
  - IDLE: req_ready=1. On accept: LATENCY=1 -> RESP; else counter=LATENCY-2 -> BUSY.
  - BUSY: req_ready=0. Counter decrements each cycle; when counter=0, -> RESP next edge.
  - RESP: resp_valid=1 for exactly this cycle; req_ready=1.
    - Accept in RESP -> same transition as from IDLE (back-to-back).
    - No accept -> IDLE.
- Memory access timing: performed on the edge entering RESP.
  - Store: bytes i where req_be[i]=1 are written; other bytes are unchanged. resp_rdata=0.
  - Load: resp_rdata = full word at captured address. Reflects all stores committed on earlier edges, so read-after-write returns new data.
  - Store with be=0: no change; response still issued.
- resp_rdata holds its value until the next RESP; only meaningful when resp_valid=1.
- Latency: response appears LATENCY cycles after the accept edge.
  - LATENCY=1 back-to-back: one response per cycle, no bubbles.
  - Otherwise: one request per LATENCY cycles.
- mem_stall = (state==BUSY) | (req_valid & ~req_ready). Combinational. It is 0 in the RESP cycle, so the pipeline advances on the same edge the response is consumed.
- No address range errors: address width equals array index width.

Test Plan:
- Reset mid-operation: assert rst while in BUSY after accepting a store of 0xDEADBEEF to address 5 -> resp_valid stays 0; a later load of address 5 returns the prior contents, not 0xDEADBEEF.
- Store then load, LATENCY=2: store 0x12345678 be=4'hF to address 3; next load of address 3 ->
  - store response: resp_valid one cycle, 2 cycles after its accept; resp_rdata=0.
  - load response: resp_rdata=0x12345678, 2 cycles after its accept.
  - req_ready=0 and mem_stall=1 during each BUSY cycle.
- Byte enables: word 7 = 0xAABBCCDD; store 0x11223344 be=4'b0101 -> load returns 0xAA22CC44. A store with be=0 leaves the word unchanged and still returns a response.
- Back-to-back, LATENCY=1: req_valid held high with loads of addresses 0,1,2,3 on consecutive cycles -> 4 consecutive resp_valid cycles in order; req_ready stays 1 and mem_stall stays 0 throughout.
- Stall under load, LATENCY=4: request held while busy -> mem_stall=1 for exactly 3 cycles after accept; resp_valid on the 4th cycle; a new request is accepted in the RESP cycle.
- Idle: req_valid=0 for 10 cycles -> resp_valid=0, mem_stall=0, req_ready=1 throughout.
